// File: rtl/riscv_pkg.sv
// Shared core-wide constants for register-file addressing and data width.
// Imported by the writeback arbiter and its scoreboard.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency LSU destinations.
// One bit per register; x0 is never pending.
module wb_scoreboard
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ok,
    input  logic [REG_ADDR_W-1:0] look_1,
    input  logic [REG_ADDR_W-1:0] look_2,
    input  logic [REG_ADDR_W-1:0] look_3,
    output logic                  hit_1,
    output logic                  hit_2,
    output logic                  hit_3,
    output logic [NUM_REGS-1:0]   pending_mask
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] mask_nxt;

    // Next mask: clear the retiring rd, then apply the new issue (set wins).
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && set_rd != REG_ZERO)
            set_vec = NUM_REGS'(1) << set_rd;
        if (clr_en && clr_rd != REG_ZERO)
            clr_vec = NUM_REGS'(1) << clr_rd;
        mask_nxt    = (pending_mask & ~clr_vec) | set_vec;
        mask_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending_mask <= '0;
        else
            pending_mask <= mask_nxt;
    end

    // Lookups; a bit being released this cycle may be re-issued at once.
    always_comb begin
        issue_ok = !pending_mask[issue_rd] ||
                   (clr_en && clr_rd == issue_rd);
        hit_1    = look_1 != REG_ZERO && pending_mask[look_1];
        hit_2    = look_2 != REG_ZERO && pending_mask[look_2];
        hit_3    = look_3 != REG_ZERO && pending_mask[look_3];
    end

endmodule

// File: rtl/rf_writeback_arb.sv
// Register-file write-port owner: arbitrates ALU and LSU results,
// tracks pending LSU writes and drives decode hazard/bypass signals.
module rf_writeback_arb
    import riscv_pkg::*;
#(
    parameter int XLEN         = riscv_pkg::XLEN,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_issue,
    input  logic [REG_ADDR_W-1:0] lsu_issue_rd,
    output logic                  lsu_issue_ok,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    input  logic [REG_ADDR_W-1:0] chk_addr_1,
    input  logic [REG_ADDR_W-1:0] chk_addr_2,
    input  logic [REG_ADDR_W-1:0] chk_rd,
    output logic                  hazard_stall,
    output logic                  byp_hit_1,
    output logic                  byp_hit_2,
    output logic [XLEN-1:0]       byp_data,
    output logic [NUM_REGS-1:0]   pending_mask
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          alu_win;
    logic          alu_fire;
    logic          lsu_fire;
    logic          sb_set;
    logic          hit_1;
    logic          hit_2;
    logic          hit_3;

    // Grant: LSU by default, ALU when alone or once it has starved.
    always_comb begin
        alu_win   = alu_valid &&
                    (!lsu_valid || starve_cnt == STARVE_MAX);
        alu_ready = alu_win;
        lsu_ready = !alu_win;
        alu_fire  = alu_valid && alu_ready;
        lsu_fire  = lsu_valid && lsu_ready;
        sb_set    = lsu_issue && lsu_issue_ok &&
                    lsu_issue_rd != REG_ZERO;
    end

    // Count consecutive ALU losses, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!alu_valid || alu_fire)
            starve_cnt <= '0;
        else if (lsu_fire && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + SW'(1);
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= 1'b0;
            if (alu_fire) begin
                rf_we    <= alu_rd != REG_ZERO;
                rf_waddr <= alu_rd;
                rf_wdata <= alu_data;
            end else if (lsu_fire) begin
                rf_we    <= lsu_rd != REG_ZERO;
                rf_waddr <= lsu_rd;
                rf_wdata <= lsu_data;
            end
        end
    end

    wb_scoreboard u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_en       (sb_set),
        .set_rd       (lsu_issue_rd),
        .clr_en       (lsu_fire),
        .clr_rd       (lsu_rd),
        .issue_rd     (lsu_issue_rd),
        .issue_ok     (lsu_issue_ok),
        .look_1       (chk_addr_1),
        .look_2       (chk_addr_2),
        .look_3       (chk_rd),
        .hit_1        (hit_1),
        .hit_2        (hit_2),
        .hit_3        (hit_3),
        .pending_mask (pending_mask)
    );

    // Decode-side stall and bypass of the write in flight.
    always_comb begin
        hazard_stall = hit_1 || hit_2 || hit_3;
        byp_hit_1    = rf_we && rf_waddr == chk_addr_1 &&
                       chk_addr_1 != REG_ZERO;
        byp_hit_2    = rf_we && rf_waddr == chk_addr_2 &&
                       chk_addr_2 != REG_ZERO;
        byp_data     = rf_wdata;
    end

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed bench for rf_writeback_arb: expected regfile writes are
// queued by stimulus and popped by an independent write-port monitor.
module tb_rf_writeback_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_issue, lsu_issue_ok;
    logic [4:0]  lsu_issue_rd;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  chk_addr_1, chk_addr_2, chk_rd;
    logic        hazard_stall, byp_hit_1, byp_hit_2;
    logic [31:0] byp_data;
    logic [31:0] pending_mask;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    rf_writeback_arb #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
        .lsu_issue_ok(lsu_issue_ok),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .chk_rd(chk_rd), .hazard_stall(hazard_stall),
        .byp_hit_1(byp_hit_1), .byp_hit_2(byp_hit_2),
        .byp_data(byp_data), .pending_mask(pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0d/%h want none",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(rf_waddr), 32'(e.addr));
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k_l;
        int k_a;
        logic exp_alu;
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_issue = 0; lsu_issue_rd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        chk_addr_1 = 0; chk_addr_2 = 0; chk_rd = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(rf_we), 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_mask", pending_mask, 0);
        rst_n = 1'b1;

        // 1: lone ALU result
        step();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_alu_ready", 32'(alu_ready), 1);
        exp_q.push_back('{5'd5, 32'hDEAD_BEEF});
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("t1_rf_we", 32'(rf_we), 1);

        // 2: LSU pending -> stall until writeback
        step();
        lsu_issue = 1; lsu_issue_rd = 7;
        @(negedge clk);
        chk("t2_issue_ok", 32'(lsu_issue_ok), 1);
        step();
        lsu_issue = 0; chk_addr_1 = 7;
        @(negedge clk);
        chk("t2_stall_set", 32'(hazard_stall), 1);
        chk("t2_mask", pending_mask, 32'h0000_0080);
        step();
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234_5678;
        @(negedge clk);
        chk("t2_lsu_ready", 32'(lsu_ready), 1);
        chk("t2_stall_hold", 32'(hazard_stall), 1);
        exp_q.push_back('{5'd7, 32'h1234_5678});
        step();
        lsu_valid = 0;
        @(negedge clk);
        chk("t2_stall_clr", 32'(hazard_stall), 0);
        chk_addr_1 = 0;

        // 3: both valid -> LSU x4 then ALU, twice
        step();
        k_l = 0; k_a = 0;
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA000_0000;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h1000_0000;
        for (int i = 0; i < 10; i++) begin
            exp_alu = (i == 4) || (i == 9);
            @(negedge clk);
            chk($sformatf("t3_alu_ready_%0d", i), 32'(alu_ready),
                32'(exp_alu));
            chk($sformatf("t3_lsu_ready_%0d", i), 32'(lsu_ready),
                32'(!exp_alu));
            if (exp_alu)
                exp_q.push_back('{5'd10, 32'hA000_0000 + k_a});
            else
                exp_q.push_back('{5'd11, 32'h1000_0000 + k_l});
            step();
            if (exp_alu) begin
                k_a++;
                alu_data = 32'hA000_0000 + k_a;
            end else begin
                k_l++;
                lsu_data = 32'h1000_0000 + k_l;
            end
        end
        alu_valid = 0; lsu_valid = 0;
        @(negedge clk);
        chk("t3_mask", pending_mask, 0);

        // 4: re-issue of a pending rd, and issue during its writeback
        step();
        lsu_issue = 1; lsu_issue_rd = 9;
        @(negedge clk);
        chk("t4_first_ok", 32'(lsu_issue_ok), 1);
        step();
        @(negedge clk);
        chk("t4_dup_ok", 32'(lsu_issue_ok), 0);
        step();
        lsu_issue = 0;
        @(negedge clk);
        chk("t4_mask_dup", pending_mask, 32'h0000_0200);
        step();
        lsu_issue = 1; lsu_issue_rd = 9;
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h0000_0999;
        @(negedge clk);
        exp_q.push_back('{5'd9, 32'h0000_0999});
        step();
        lsu_issue = 0; lsu_data = 32'h0000_0AAA;
        @(negedge clk);
        chk("t4_set_wins", pending_mask, 32'h0000_0200);
        exp_q.push_back('{5'd9, 32'h0000_0AAA});
        step();
        lsu_valid = 0;
        @(negedge clk);
        chk("t4_mask_clr", pending_mask, 0);

        // 5: x0 destinations
        step();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
        @(negedge clk);
        chk("t5_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 0;
        lsu_issue = 1; lsu_issue_rd = 0;
        @(negedge clk);
        chk("t5_rf_we", 32'(rf_we), 0);
        chk("t5_x0_ok", 32'(lsu_issue_ok), 1);
        step();
        lsu_issue = 0;
        @(negedge clk);
        chk("t5_mask", pending_mask, 0);

        // 6: bypass of the write in flight
        step();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hCAFE_F00D;
        chk_addr_1 = 4; chk_addr_2 = 3;
        @(negedge clk);
        exp_q.push_back('{5'd3, 32'hCAFE_F00D});
        step();
        alu_valid = 0;
        @(negedge clk);
        chk("t6_byp_hit_2", 32'(byp_hit_2), 1);
        chk("t6_byp_hit_1", 32'(byp_hit_1), 0);
        chk("t6_byp_data", byp_data, 32'hCAFE_F00D);

        // 6b: reset in the middle of a transfer
        step();
        chk_addr_1 = 0; chk_addr_2 = 0; chk_rd = 4;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h77;
        lsu_issue = 1; lsu_issue_rd = 4;
        @(posedge clk);
        #1;
        alu_valid = 0; lsu_issue = 0;
        chk("t6_pre_we", 32'(rf_we), 1);
        chk("t6_pre_mask", pending_mask, 32'h0000_0010);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 32'(rf_we), 0);
        chk("t6_rst_waddr", 32'(rf_waddr), 0);
        chk("t6_rst_wdata", rf_wdata, 0);
        chk("t6_rst_mask", pending_mask, 0);
        chk("t6_rst_stall", 32'(hazard_stall), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
